// File: rtl/depth_event_normalizer.sv
// Multi-channel depth event normalizer: per-channel update_id sequencing,
// flag classification, optional stale drop, and a single registered output stage.
module depth_event_normalizer #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
   parameter int unsigned ID_W       = 64,
   parameter int unsigned DROP_STALE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH_W-1:0] in_ch,
   input  logic [63:0]     ts_ns,
   input  logic [ID_W-1:0] update_id,
   input  logic [7:0]      side,
   input  logic [31:0]     price_f32,
   input  logic [31:0]     qty_f32,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CH_W-1:0] out_ch,
   output logic [63:0]     out_ts_ns,
   output logic [ID_W-1:0] out_update_id,
   output logic            out_side,
   output logic [31:0]     out_price,
   output logic [31:0]     out_qty,
   output logic [7:0]      out_flags,
   output logic [31:0]     gap_cnt,
   output logic [31:0]     stale_cnt,
   output logic [31:0]     bad_cnt
);

   localparam int unsigned CNT_W = 32;
   localparam logic [ID_W-1:0] ID_MAX = '1;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [63:0]     ts;
      logic [ID_W-1:0] id;
      logic            side;
      logic [31:0]     price;
      logic [31:0]     qty;
      logic [7:0]      flags;
   } evt_t;

   evt_t             evt_q, evt_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] stale_cnt_q, stale_cnt_d;
   logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
   logic [N_CH-1:0]  seen_q, seen_d;
   logic [ID_W-1:0]  last_id_q [N_CH];
   logic [ID_W-1:0]  last_id_d [N_CH];

   logic            acc, ch_ok, cur_seen, wrap0;
   logic            is_first, is_gap, is_stale, bad_side, is_del, drop, fwd;
   logic [ID_W-1:0] cur_last;
   logic [7:0]      flags;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   assign in_ready = !out_valid_q || out_ready;

   // Classification, next-state and output-register load
   always_comb begin
      acc      = in_valid && in_ready;
      ch_ok    = {1'b0, in_ch} < (CH_W+1)'(N_CH);
      cur_seen = 1'b0;
      cur_last = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (in_ch == CH_W'(i)) begin
            cur_seen = seen_q[i];
            cur_last = last_id_q[i];
         end
      end

      // An all-ones last_id followed by id 0 is a gap, never a wrap
      wrap0    = (cur_last == ID_MAX) && (update_id == '0);
      is_first = !cur_seen;
      is_gap   = cur_seen && (((update_id > cur_last) && (update_id != cur_last + ID_W'(1))) || wrap0);
      is_stale = cur_seen && (update_id < cur_last) && !wrap0;
      bad_side = side > 8'd1;
      is_del   = qty_f32[30:0] == 31'd0;
      flags    = {3'b000, is_del, is_first, bad_side, is_stale, is_gap};
      drop     = is_stale && (DROP_STALE != 0);
      fwd      = acc && ch_ok && !drop;

      evt_d       = evt_q;
      out_valid_d = out_valid_q;
      seen_d      = seen_q;
      last_id_d   = last_id_q;

      if (fwd) begin
         out_valid_d = 1'b1;
         evt_d.ch    = in_ch;
         evt_d.ts    = ts_ns;
         evt_d.id    = update_id;
         evt_d.side  = side != 8'd0;
         evt_d.price = price_f32;
         evt_d.qty   = qty_f32;
         evt_d.flags = flags;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (acc && ch_ok && !is_stale) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            if (in_ch == CH_W'(i)) begin
               seen_d[i]    = 1'b1;
               last_id_d[i] = update_id;
            end
         end
      end

      gap_cnt_d   = sat_inc(gap_cnt_q,   acc && ch_ok && is_gap);
      stale_cnt_d = sat_inc(stale_cnt_q, acc && ch_ok && is_stale);
      bad_cnt_d   = sat_inc(bad_cnt_q,   acc && (!ch_ok || bad_side));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q       <= '0;
         out_valid_q <= 1'b0;
         gap_cnt_q   <= '0;
         stale_cnt_q <= '0;
         bad_cnt_q   <= '0;
         seen_q      <= '0;
         for (int i = 0; i < int'(N_CH); i++) last_id_q[i] <= '0;
      end else begin
         evt_q       <= evt_d;
         out_valid_q <= out_valid_d;
         gap_cnt_q   <= gap_cnt_d;
         stale_cnt_q <= stale_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         seen_q      <= seen_d;
         for (int i = 0; i < int'(N_CH); i++) last_id_q[i] <= last_id_d[i];
      end
   end

   assign out_valid     = out_valid_q;
   assign out_ch        = evt_q.ch;
   assign out_ts_ns     = evt_q.ts;
   assign out_update_id = evt_q.id;
   assign out_side      = evt_q.side;
   assign out_price     = evt_q.price;
   assign out_qty       = evt_q.qty;
   assign out_flags     = evt_q.flags;
   assign gap_cnt       = gap_cnt_q;
   assign stale_cnt     = stale_cnt_q;
   assign bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_depth_event_normalizer.sv
// Directed bench for depth_event_normalizer: one instance drops stale events,
// a second forwards them flagged; both see identical stimulus.
module tb_depth_event_normalizer;

   localparam int unsigned N_CH = 3;
   localparam int unsigned CH_W = 2;
   localparam int unsigned ID_W = 64;
   localparam logic [31:0] ONE  = 32'h3F80_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n, in_valid, out_ready;
   logic [CH_W-1:0] in_ch;
   logic [63:0]     ts_ns;
   logic [ID_W-1:0] update_id;
   logic [7:0]      side;
   logic [31:0]     price_f32, qty_f32;

   logic            r1, v1, s1, r0, v0, s0;
   logic [CH_W-1:0] ch1, ch0;
   logic [63:0]     ts1, ts0;
   logic [ID_W-1:0] id1, id0;
   logic [31:0]     pr1, q1, pr0, q0, g1, st1, b1, g0, st0, b0;
   logic [7:0]      f1, f0;

   depth_event_normalizer #(.N_CH(N_CH), .ID_W(ID_W), .DROP_STALE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_ch(in_ch),
      .ts_ns(ts_ns), .update_id(update_id), .side(side), .price_f32(price_f32),
      .qty_f32(qty_f32), .out_valid(v1), .out_ready(out_ready), .out_ch(ch1),
      .out_ts_ns(ts1), .out_update_id(id1), .out_side(s1), .out_price(pr1),
      .out_qty(q1), .out_flags(f1), .gap_cnt(g1), .stale_cnt(st1), .bad_cnt(b1));

   depth_event_normalizer #(.N_CH(N_CH), .ID_W(ID_W), .DROP_STALE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_ch(in_ch),
      .ts_ns(ts_ns), .update_id(update_id), .side(side), .price_f32(price_f32),
      .qty_f32(qty_f32), .out_valid(v0), .out_ready(out_ready), .out_ch(ch0),
      .out_ts_ns(ts0), .out_update_id(id0), .out_side(s0), .out_price(pr0),
      .out_qty(q0), .out_flags(f0), .gap_cnt(g0), .stale_cnt(st0), .bad_cnt(b0));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [CH_W-1:0] ch;
      logic [63:0]     id;
      logic [7:0]      side;
      logic [31:0]     qty;
      logic            ev1;   // output expected from the dropping instance
      logic            ev0;   // output expected from the forwarding instance
      logic [7:0]      flags;
      logic            oside;
   } vec_t;

   vec_t tbl [12];

   // Drive one event at the falling edge, check outputs just after the accepting edge
   task automatic step(input vec_t v, input int k);
      @(negedge clk);
      in_valid  = 1'b1;
      in_ch     = v.ch;
      update_id = v.id;
      side      = v.side;
      qty_f32   = v.qty;
      price_f32 = 32'h4000_0000 + 32'(k);
      ts_ns     = 64'(k) * 64'd1000 + 64'd7;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", k), 64'(v1), 64'(v.ev1));
      if (v.ev1) begin
         chk($sformatf("v%0d flags", k), 64'(f1), 64'(v.flags));
         chk($sformatf("v%0d side", k), 64'(s1), 64'(v.oside));
         chk($sformatf("v%0d id", k), id1, v.id);
         chk($sformatf("v%0d ch", k), 64'(ch1), 64'(v.ch));
         chk($sformatf("v%0d ts", k), ts1, 64'(k) * 64'd1000 + 64'd7);
         chk($sformatf("v%0d price", k), 64'(pr1), 64'(32'h4000_0000 + 32'(k)));
         chk($sformatf("v%0d qty", k), 64'(q1), 64'(v.qty));
      end
      chk($sformatf("v%0d valid0", k), 64'(v0), 64'(v.ev0));
      if (v.ev0) begin
         chk($sformatf("v%0d flags0", k), 64'(f0), 64'(v.flags));
         chk($sformatf("v%0d id0", k), id0, v.id);
      end
   endtask

   logic [63:0] nid, exp_rx;
   vec_t        vr;

   initial begin
      tbl[0]  = '{2'd0, 64'd100, 8'd0, ONE,          1'b1, 1'b1, 8'h08, 1'b0};
      tbl[1]  = '{2'd0, 64'd100, 8'd1, ONE,          1'b1, 1'b1, 8'h00, 1'b1};
      tbl[2]  = '{2'd0, 64'd101, 8'd0, ONE,          1'b1, 1'b1, 8'h00, 1'b0};
      tbl[3]  = '{2'd1, 64'd10,  8'd0, ONE,          1'b1, 1'b1, 8'h08, 1'b0};
      tbl[4]  = '{2'd1, 64'd13,  8'd0, ONE,          1'b1, 1'b1, 8'h01, 1'b0};
      tbl[5]  = '{2'd1, 64'd12,  8'd0, ONE,          1'b0, 1'b1, 8'h02, 1'b0};
      tbl[6]  = '{2'd1, 64'd14,  8'd0, ONE,          1'b1, 1'b1, 8'h00, 1'b0};
      tbl[7]  = '{2'd2, 64'd5,   8'd7, 32'h8000_0000, 1'b1, 1'b1, 8'h1C, 1'b1};
      tbl[8]  = '{2'd3, 64'd20,  8'd0, ONE,          1'b0, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{2'd2, '1,      8'd0, ONE,          1'b1, 1'b1, 8'h01, 1'b0};
      tbl[10] = '{2'd2, 64'd0,   8'd0, ONE,          1'b1, 1'b1, 8'h01, 1'b0};
      tbl[11] = '{2'd0, 64'd102, 8'd0, 32'h0,        1'b1, 1'b1, 8'h10, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_ch = '0; ts_ns = '0;
      update_id = '0; side = '0; price_f32 = '0; qty_f32 = '0;
      #12;
      chk("rst valid", 64'(v1), 64'd0);
      chk("rst flags", 64'(f1), 64'd0);
      chk("rst cnt", 64'(g1 | st1 | b1), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle in_ready", 64'(r1), 64'd1);

      for (int i = 0; i < 12; i++) begin
         step(tbl[i], i);
         if (i == 4) chk("gap_cnt after gap", 64'(g1), 64'd1);
         if (i == 5) chk("stale_cnt after drop", 64'(st1), 64'd1);
         if (i == 7) chk("bad_cnt after bad side", 64'(b1), 64'd1);
         if (i == 8) chk("bad_cnt after bad ch", 64'(b1), 64'd2);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("gap_cnt", 64'(g1), 64'd3);
      chk("stale_cnt", 64'(st1), 64'd1);
      chk("bad_cnt", 64'(b1), 64'd2);
      chk("stale_cnt fwd", 64'(st0), 64'd1);
      chk("gap_cnt fwd", 64'(g0), 64'd3);
      @(negedge clk);
      chk("drained", 64'(v1), 64'd0);

      // Backpressure: out_ready low for five cycles under continuous input
      nid    = 64'd103;
      exp_rx = 64'd103;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         out_ready = (c >= 5);
         in_valid  = (c < 20);
         in_ch     = 2'd0;
         update_id = nid;
         side      = 8'd0;
         qty_f32   = ONE;
         #1;
         if (c >= 1 && c <= 4) begin
            chk($sformatf("bp%0d in_ready", c), 64'(r1), 64'd0);
            chk($sformatf("bp%0d held valid", c), 64'(v1), 64'd1);
            chk($sformatf("bp%0d held id", c), id1, 64'd103);
         end
         if (c >= 5 && c < 20) chk($sformatf("bp%0d ready", c), 64'(r1), 64'd1);
         if (v1 && out_ready) begin
            chk($sformatf("rx%0d id", c), id1, exp_rx);
            chk($sformatf("rx%0d flags", c), 64'(f1), 64'd0);
            exp_rx = exp_rx + 64'd1;
         end
         if (in_valid && r1) nid = nid + 64'd1;
      end
      chk("stream count", exp_rx, nid);
      chk("stream sent", nid, 64'd103 + 64'd16);

      // Asynchronous reset while an output is pending
      @(negedge clk);
      in_valid  = 1'b1;
      update_id = nid;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-rst valid", 64'(v1), 64'd1);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("async rst valid", 64'(v1), 64'd0);
      chk("async rst id", id1, 64'd0);
      chk("async rst ts", ts1, 64'd0);
      chk("async rst gap", 64'(g1), 64'd0);
      chk("async rst bad", 64'(b1), 64'd0);
      chk("async rst stale", 64'(st1), 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      vr = '{2'd0, 64'd50, 8'd0, ONE, 1'b1, 1'b1, 8'h08, 1'b0};
      step(vr, 20);
      @(negedge clk);
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/depth_event_normalizer.md
# depth_event_normalizer

Parametrised, multi-channel successor to the single-stream depth parser. It sits between the unpack stage and the order-book update logic. Each incoming depth level carries a channel (symbol) index. The block:
- registers the level into a normalised event;
- checks update_id sequencing per channel;
- classifies side, deletion and anomalies into flags;
- applies valid/ready backpressure.

Stale events are optionally filtered, and saturating error counters are kept.

## Interface
Parameters:
- N_CH, 4: number of symbol channels, 1..64.
- CH_W, $clog2(N_CH) min 1: channel index width.
- ID_W, 64: update_id width.
- DROP_STALE, 1: 1 = discard stale events; 0 = forward them flagged.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input event present
- in_ready  out  1  block accepts input this cycle
- in_ch  in  CH_W  channel index
- ts_ns  in  64  receive timestamp
- update_id  in  ID_W  exchange update id
- side  in  8  raw side byte, 0 = bid, 1 = ask
- price_f32  in  32  price, IEEE754 single
- qty_f32  in  32  quantity, IEEE754 single
- out_valid  out  1  output event present
- out_ready  in  1  downstream accepts
- out_ch  out  CH_W  channel index
- out_ts_ns  out  64  timestamp
- out_update_id  out  ID_W  update id
- out_side  out  1  0 = bid, 1 = ask
- out_price  out  32  price, passed through
- out_qty  out  32  quantity, passed through
- out_flags  out  8  bit0 GAP, bit1 STALE, bit2 BAD_SIDE, bit3 FIRST, bit4 DELETE, bits7:5 = 0
- gap_cnt  out  32  saturating count of GAP events
- stale_cnt  out  32  saturating count of STALE events, dropped or forwarded
- bad_cnt  out  32  saturating count of BAD_SIDE events plus out-of-range channel events

## Operation
- Accept occurs when in_valid && in_ready. All checks below are evaluated on accept.
- Per-channel state:
  - seen[N_CH] bit.
  - last_id[N_CH], ID_W wide.
- Sequencing for an accepted event on channel c, in_ch < N_CH:
  - !seen[c]: FIRST.
  - update_id == last_id or last_id+1: clean. Equal ids mean multiple levels of one diff.
  - update_id > last_id+1: GAP.
  - update_id < last_id: STALE.
  - Comparisons are unsigned. If last_id is all-ones, update_id == 0 is GAP, not wrap.
- State update on accept:
  - Every non-STALE event sets seen[c]=1 and last_id[c]=update_id.
  - A STALE event leaves the state unchanged.
- side: 0 gives out_side=0, 1 gives out_side=1. Any other value gives out_side=1 with BAD_SIDE set.
- DELETE is set when qty_f32[30:0]==0 (±0.0).
- Flags combine, e.g. FIRST|DELETE.
- STALE event with DROP_STALE=1: accepted (consumed), stale_cnt incremented, no output produced.
- in_ch >= N_CH: accepted and discarded, no output, bad_cnt incremented, no state touched.
- Counters saturate at 32'hFFFF_FFFF.
- If one event is both BAD_SIDE and GAP, gap_cnt and bad_cnt each increment by 1.

## Timing
- Single output register. in_ready = !out_valid || out_ready, combinational from out_ready.
- Latency: event accepted at edge t appears with out_valid=1 after edge t, 1 cycle.
- Output fields are held stable while out_valid && !out_ready.
- out_valid clears on an out_ready handshake unless a new forwarded event is accepted on the same edge. Full throughput is 1 event/cycle.
- A dropped event accepted while out_valid && out_ready clears out_valid.
- Back-to-back events on the same channel: the second event is checked against the state written by the first, with no bubble.
- Reset, asynchronous, also valid mid-transfer:
  - out_valid=0, all out_* fields 0, counters 0.
  - seen all 0, last_id all 0.
  - In-flight output is lost.
- in_ready is 1 in reset-released idle.

## Test plan
- Ch0 ids 100,100,101 with side 0,1,0, out_ready=1 -> out_flags 0x08,0x00,0x00; out_side 0,1,0; each 1 cycle after accept.
- Ch1 ids 10 then 13 -> second event GAP (0x01), gap_cnt=1. Ch1 then id 12 with DROP_STALE=1 -> no output, stale_cnt=1; a following id 14 is clean.
- Same stale stimulus with DROP_STALE=0 -> output flags 0x02, last_id stays 13.
- side=8'd7, qty_f32=32'h8000_0000 on a fresh channel -> flags 0x1C, out_side=1, bad_cnt=1. in_ch=N_CH -> no output, bad_cnt=2.
- Hold out_ready=0 for 5 cycles with continuous in_valid -> in_ready=0 after the first accept, output held unchanged. Release -> stream resumes at 1/cycle with no loss or duplication.
- Assert rst_n low mid-stream with out_valid=1 -> all outputs and counters 0 immediately. The next ch0 event is flagged FIRST.
